// File: rtl/cdc_stable_capture.sv
// Qualifies a synchronized multi-bit bus by requiring a stable value over several edges,
// suppresses repeats of the last committed word and queues new words in a FWFT FIFO.
module cdc_stable_capture #(
  parameter int DATA_W     = 8,
  parameter int STABLE_CYC = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk2_slow,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             sync_data,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_cnt
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] STAB_MAX  = CW'(STABLE_CYC);
  localparam logic [CW-1:0] STAB_CMT  = CW'(STABLE_CYC - 1);
  localparam logic [PW:0]   FULL_LVL  = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {SETTLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t              state_r, state_next_s;
  logic [DATA_W-1:0]   prev_r, last_r, head_r;
  logic [CW-1:0]       stab_r, stab_next_s;
  logic                last_valid_r, valid_r;
  logic [DATA_W-1:0]   mem_r [FIFO_DEPTH];
  logic [PW-1:0]       wr_r, rd_r, rd_next_s;
  logic [PW:0]         count_r, count_next_s;
  logic [7:0]          drop_r;
  logic                same_s, commit_s, push_req_s, full_s, pop_s, push_s, drop_s;
  logic [DATA_W-1:0]   head_next_s;

  // stability compare and saturating match counter
  always_comb begin
    same_s = (sync_data == prev_r);
    if (!same_s) begin
      stab_next_s = {CW{1'b0}};
    end else if (stab_r == STAB_MAX) begin
      stab_next_s = stab_r;
    end else begin
      stab_next_s = stab_r + CW'(1);
    end
  end

  // settle/lock state machine: one commit per stable period
  always_comb begin
    state_next_s = state_r;
    commit_s     = 1'b0;
    case (state_r)
      SETTLE: begin
        if (same_s && (stab_r == STAB_CMT)) begin
          commit_s     = 1'b1;
          state_next_s = LOCKED;
        end else begin
          state_next_s = SETTLE;
        end
      end
      LOCKED: begin
        if (!same_s) state_next_s = SETTLE;
        else         state_next_s = LOCKED;
      end
      default: state_next_s = SETTLE;
    endcase
    push_req_s = commit_s && (!last_valid_r || (sync_data != last_r));
  end

  // FIFO control; the head register is preloaded so out_data is a flop output
  always_comb begin
    full_s    = (count_r == FULL_LVL);
    pop_s     = (count_r != {(PW + 1){1'b0}}) && out_ready;
    push_s    = push_req_s && (!full_s || pop_s);
    drop_s    = push_req_s && full_s && !pop_s;
    rd_next_s = pop_s ? rd_r + PW'(1) : rd_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + (PW + 1)'(1);
      2'b01:   count_next_s = count_r - (PW + 1)'(1);
      default: count_next_s = count_r;
    endcase
    // a word written into the slot that becomes head bypasses the memory
    if (push_s && (wr_r == rd_next_s)) begin
      head_next_s = sync_data;
    end else begin
      head_next_s = mem_r[rd_next_s];
    end
  end

  // all state registers with synchronous active-low reset
  always_ff @(posedge clk2_slow) begin
    if (!rst) begin
      state_r      <= SETTLE;
      prev_r       <= {DATA_W{1'b0}};
      stab_r       <= {CW{1'b0}};
      last_r       <= {DATA_W{1'b0}};
      last_valid_r <= 1'b0;
      wr_r         <= {PW{1'b0}};
      rd_r         <= {PW{1'b0}};
      count_r      <= {(PW + 1){1'b0}};
      head_r       <= {DATA_W{1'b0}};
      valid_r      <= 1'b0;
      drop_r       <= 8'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      prev_r  <= sync_data;
      stab_r  <= stab_next_s;
      if (commit_s) begin
        last_r       <= sync_data;
        last_valid_r <= 1'b1;
      end
      if (push_s) begin
        mem_r[wr_r] <= sync_data;
        wr_r        <= wr_r + PW'(1);
      end
      rd_r    <= rd_next_s;
      count_r <= count_next_s;
      head_r  <= head_next_s;
      valid_r <= (count_next_s != {(PW + 1){1'b0}});
      if (drop_s && (drop_r != 8'hFF)) drop_r <= drop_r + 8'd1;
    end
  end

  assign out_data   = head_r;
  assign out_valid  = valid_r;
  assign fifo_level = count_r;
  assign drop_cnt   = drop_r;

endmodule

// File: tb/tb_cdc_stable_capture.sv
// Directed bench for cdc_stable_capture (STABLE_CYC=3, FIFO_DEPTH=4, DATA_W=8).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_cdc_stable_capture;

  logic       clk2_slow;
  logic       rst;
  logic [7:0] sync_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] fifo_level;
  logic [7:0] drop_cnt;

  int total_cnt;
  int bad_cnt;

  cdc_stable_capture #(.DATA_W(8), .STABLE_CYC(3), .FIFO_DEPTH(4)) dut (
    .clk2_slow (clk2_slow),
    .rst       (rst),
    .sync_data (sync_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fifo_level(fifo_level),
    .drop_cnt  (drop_cnt)
  );

  initial clk2_slow = 1'b0;
  always #5 clk2_slow = ~clk2_slow;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk2_slow);
      #1;
    end
  endtask

  // new bus value commits on the 4th edge after it appears
  task automatic commit_word(input logic [7:0] v);
    sync_data = v;
    tick(4);
  endtask

  task automatic check_empty_reset(input string tag);
    check_val({tag, "_valid"}, 32'(out_valid), 32'd0);
    check_val({tag, "_level"}, 32'(fifo_level), 32'd0);
    check_val({tag, "_data"}, 32'(out_data), 32'd0);
    check_val({tag, "_drop"}, 32'(drop_cnt), 32'd0);
  endtask

  initial begin
    logic [7:0] exp_a [4];
    total_cnt = 0;
    bad_cnt   = 0;
    exp_a[0] = 8'hA1; exp_a[1] = 8'hA2; exp_a[2] = 8'hA3; exp_a[3] = 8'hA4;

    // 1: release reset with 0x5A held, consumer ready
    rst = 1'b0; sync_data = 8'h5A; out_ready = 1'b1;
    tick(1);
    check_empty_reset("t1_rst");
    rst = 1'b1;
    tick(3);
    check_val("t1_early_valid", 32'(out_valid), 32'd0);
    tick(1);
    check_val("t1_valid", 32'(out_valid), 32'd1);
    check_val("t1_data", 32'(out_data), 32'h5A);
    check_val("t1_level", 32'(fifo_level), 32'd1);
    tick(1);
    check_val("t1_popped_valid", 32'(out_valid), 32'd0);
    check_val("t1_popped_level", 32'(fifo_level), 32'd0);

    // 2: commit 0x11, glitch to 0x13 for two edges, back to 0x11 -> no push
    commit_word(8'h11);
    check_val("t2_commit_valid", 32'(out_valid), 32'd1);
    check_val("t2_commit_data", 32'(out_data), 32'h11);
    tick(1);
    check_val("t2_popped", 32'(out_valid), 32'd0);
    sync_data = 8'h13;
    tick(2);
    sync_data = 8'h11;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check_val("t2_no_push", 32'(out_valid), 32'd0);
    end

    // 3: change to 0x22 and hold -> pushed on the 4th edge after the change
    sync_data = 8'h22;
    tick(3);
    check_val("t3_before", 32'(out_valid), 32'd0);
    tick(1);
    check_val("t3_valid", 32'(out_valid), 32'd1);
    check_val("t3_data", 32'(out_data), 32'h22);
    tick(1);
    check_val("t3_popped", 32'(out_valid), 32'd0);

    // 4: stalled consumer, five commits -> full plus one drop
    out_ready = 1'b0;
    commit_word(8'hA1);
    check_val("t4_l1", 32'(fifo_level), 32'd1);
    commit_word(8'hA2);
    commit_word(8'hA3);
    commit_word(8'hA4);
    check_val("t4_full", 32'(fifo_level), 32'd4);
    check_val("t4_nodrop", 32'(drop_cnt), 32'd0);
    commit_word(8'hA5);
    check_val("t4_level", 32'(fifo_level), 32'd4);
    check_val("t4_drop", 32'(drop_cnt), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_val("t4_drain_data", 32'(out_data), 32'(exp_a[i]));
      check_val("t4_drain_valid", 32'(out_valid), 32'd1);
      tick(1);
    end
    check_val("t4_empty", 32'(out_valid), 32'd0);
    check_val("t4_empty_level", 32'(fifo_level), 32'd0);

    // 5: commit and pop on the same edge while full
    out_ready = 1'b0;
    commit_word(8'hB1);
    commit_word(8'hB2);
    commit_word(8'hB3);
    commit_word(8'hB4);
    sync_data = 8'hB5;
    tick(3);
    check_val("t5_pre_level", 32'(fifo_level), 32'd4);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    check_val("t5_level", 32'(fifo_level), 32'd4);
    check_val("t5_drop", 32'(drop_cnt), 32'd1);
    check_val("t5_head", 32'(out_data), 32'hB2);
    out_ready = 1'b1;
    check_val("t5_d0", 32'(out_data), 32'hB2);
    tick(1);
    check_val("t5_d1", 32'(out_data), 32'hB3);
    tick(1);
    check_val("t5_d2", 32'(out_data), 32'hB4);
    tick(1);
    check_val("t5_d3", 32'(out_data), 32'hB5);
    check_val("t5_d3_level", 32'(fifo_level), 32'd1);
    tick(1);
    check_val("t5_empty", 32'(out_valid), 32'd0);

    // 6: reset mid-operation with level 3 and drop_cnt 2
    out_ready = 1'b0;
    commit_word(8'hC1);
    commit_word(8'hC2);
    commit_word(8'hC3);
    commit_word(8'hC4);
    commit_word(8'hC5);
    check_val("t6_drop2", 32'(drop_cnt), 32'd2);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    check_val("t6_level3", 32'(fifo_level), 32'd3);
    check_val("t6_head", 32'(out_data), 32'hC2);
    rst = 1'b0;
    tick(1);
    check_empty_reset("t6_rst");
    rst = 1'b1;
    tick(3);
    check_val("t6_before", 32'(out_valid), 32'd0);
    tick(1);
    check_val("t6_repush_valid", 32'(out_valid), 32'd1);
    check_val("t6_repush_data", 32'(out_data), 32'hC5);
    check_val("t6_repush_level", 32'(fifo_level), 32'd1);

    // zero held through reset commits one edge earlier
    rst = 1'b0; sync_data = 8'h00;
    tick(1);
    rst = 1'b1;
    tick(2);
    check_val("z_before", 32'(out_valid), 32'd0);
    tick(1);
    check_val("z_valid", 32'(out_valid), 32'd1);
    check_val("z_data", 32'(out_data), 32'h00);
    check_val("z_level", 32'(fifo_level), 32'd1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
